// File: rtl/k2red_stream.sv
// k2red_stream: streaming K2-RED modular reduction for Proth primes
// Q = K*2^M + 1, where K is a runtime-configured sum of signed powers of two.
// It returns R = K^2*A mod Q through a five-stage valid/ready pipeline.
// The pipeline carries a sideband tag alongside each word.
// Optional build macro: K2RED_LAZY_OUT_EN. It drops the final correction
// stage, giving a latency of 4 and a signed W+2 bit out_r in (-Q, 2Q).
module k2red_stream #(
   parameter int W  = 32,
   parameter int NT = 4,
   parameter int TW = 4,
   localparam int SW = $clog2(2*W),
`ifdef K2RED_LAZY_OUT_EN
   localparam int OW = W + 2
`else
   localparam int OW = W
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*W-1:0]       in_a,
   input  logic [TW-1:0]        in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef K2RED_LAZY_OUT_EN
   output logic signed [OW-1:0] out_r,
`else
   output logic [OW-1:0]        out_r,
`endif
   output logic [TW-1:0]        out_tag,
   input  logic                 cfg_we,
   output logic                 cfg_ready,
   input  logic [W-1:0]         cfg_q,
   input  logic [SW-1:0]        cfg_m,
   input  logic [NT*SW-1:0]     cfg_sh,
   input  logic [NT-1:0]        cfg_neg,
   input  logic [NT-1:0]        cfg_en
);

   // Signed internal width. Two guard bits keep K*XL - XH from truncating.
   localparam int DW = 2*W + 2;
`ifdef K2RED_LAZY_OUT_EN
   localparam int NS = 4;
`else
   localparam int NS = 5;
`endif

   typedef logic signed [DW-1:0] dw_t;

   // Configuration registers.
   logic [W-1:0]       q_reg;
   logic [SW-1:0]      m_reg;
   logic [NT*SW-1:0]   sh_reg;
   logic [NT-1:0]      neg_reg;
   logic [NT-1:0]      en_reg;

   // Pipeline state. Bit i of v_reg is the valid bit of stage Si.
   logic [NS-1:0]      v_reg;
   logic [TW-1:0]      tag_reg [NS];
   dw_t                al_reg;
   dw_t                ah_reg;
   dw_t                c1_reg;
   dw_t                xl_reg;
   dw_t                xh_reg;
   dw_t                c2_reg;
`ifndef K2RED_LAZY_OUT_EN
   logic [W-1:0]       r_reg;
`endif

   logic               adv;
   logic               cfg_acc;
   logic               in_acc;
   dw_t                mask;
   dw_t                a_ext;
   dw_t                q_ext;
   dw_t                c1_next;
   dw_t                c2_next;
   // Running sums of the K*x partial products for the two rounds.
   dw_t                acc1 [NT+1];
   dw_t                acc2 [NT+1];

   // A single advance signal moves or freezes the whole pipeline.
   assign out_valid = v_reg[NS-1];
   assign adv       = !out_valid || out_ready;
   assign cfg_ready = (v_reg == '0);
   assign cfg_acc   = cfg_we && cfg_ready;
   // No input is taken in the cycle a configuration write lands.
   assign in_ready  = adv && !cfg_acc;
   assign in_acc    = in_valid && in_ready;

   assign mask  = (dw_t'(1) << m_reg) - dw_t'(1);
   assign a_ext = dw_t'({2'b00, in_a});
   assign q_ext = dw_t'({{(DW-W){1'b0}}, q_reg});

   // K*x is built as shifted, signed copies of x, summed one term at a time.
   assign acc1[0] = '0;
   assign acc2[0] = '0;
   generate
      for (genvar gi = 0; gi < NT; gi++) begin : g_term
         logic [SW-1:0] sh;
         dw_t           t1;
         dw_t           t2;
         assign sh = sh_reg[gi*SW +: SW];
         assign t1 = !en_reg[gi] ? dw_t'(0) :
                     neg_reg[gi] ? -(al_reg << sh) : (al_reg << sh);
         assign t2 = !en_reg[gi] ? dw_t'(0) :
                     neg_reg[gi] ? -(xl_reg << sh) : (xl_reg << sh);
         assign acc1[gi+1] = acc1[gi] + t1;
         assign acc2[gi+1] = acc2[gi] + t2;
      end
   endgenerate

   assign c1_next = acc1[NT] - ah_reg;
   assign c2_next = acc2[NT] - xh_reg;

   // Configuration capture. Writes land only while the pipeline is empty,
   // so every stage can read these registers directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg   <= '0;
         m_reg   <= '0;
         sh_reg  <= '0;
         neg_reg <= '0;
         en_reg  <= '0;
      end else if (cfg_acc) begin
         q_reg   <= cfg_q;
         m_reg   <= cfg_m;
         sh_reg  <= cfg_sh;
         neg_reg <= cfg_neg;
         en_reg  <= cfg_en;
      end
   end

   // Pipeline stages. Data, tag and valid all advance together or all hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_reg  <= '0;
         for (int i = 0; i < NS; i++) tag_reg[i] <= '0;
         al_reg <= '0;
         ah_reg <= '0;
         c1_reg <= '0;
         xl_reg <= '0;
         xh_reg <= '0;
         c2_reg <= '0;
`ifndef K2RED_LAZY_OUT_EN
         r_reg  <= '0;
`endif
      end else if (adv) begin
         v_reg      <= {v_reg[NS-2:0], in_acc};
         tag_reg[0] <= in_tag;
         for (int i = 1; i < NS; i++) tag_reg[i] <= tag_reg[i-1];
         // S0: split A into its low M bits and the high part.
         al_reg <= a_ext & mask;
         ah_reg <= a_ext >>> m_reg;
         // S1: first round.
         c1_reg <= c1_next;
         // S2: split C1. C1 may be negative, so the high part shifts arithmetically.
         xl_reg <= c1_reg & mask;
         xh_reg <= c1_reg >>> m_reg;
         // S3: second round.
         c2_reg <= c2_next;
`ifndef K2RED_LAZY_OUT_EN
         // S4: a single add or subtract of Q folds C2 from (-Q, 2Q) into [0, Q).
         if (c2_reg >= q_ext)
            r_reg <= W'(c2_reg - q_ext);
         else if (c2_reg[DW-1])
            r_reg <= W'(c2_reg + q_ext);
         else
            r_reg <= W'(c2_reg);
`endif
      end
   end

`ifdef K2RED_LAZY_OUT_EN
   assign out_r = OW'(c2_reg);
`else
   assign out_r = r_reg;
`endif
   assign out_tag = tag_reg[NS-1];

endmodule

// File: tb/tb_k2red_stream.sv
// tb_k2red_stream: directed and randomized checks of k2red_stream against a
// plain modular-arithmetic reference (K^2*A mod Q) with an in-order queue.
module tb_k2red_stream;
   localparam int W  = 24;
   localparam int NT = 4;
   localparam int TW = 4;
   localparam int SW = $clog2(2*W);
   localparam int AW = 2*W;
`ifdef K2RED_LAZY_OUT_EN
   localparam int OW  = W + 2;
   localparam int LAT = 4;
`else
   localparam int OW  = W;
   localparam int LAT = 5;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [AW-1:0]     in_a = '0;
   logic [TW-1:0]     in_tag = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [OW-1:0]     out_r;
   logic [TW-1:0]     out_tag;
   logic              cfg_we = 1'b0;
   logic              cfg_ready;
   logic [W-1:0]      cfg_q = '0;
   logic [SW-1:0]     cfg_m = '0;
   logic [NT*SW-1:0]  cfg_sh = '0;
   logic [NT-1:0]     cfg_neg = '0;
   logic [NT-1:0]     cfg_en = '0;

   k2red_stream #(.W(W), .NT(NT), .TW(TW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
      .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_q(cfg_q), .cfg_m(cfg_m),
      .cfg_sh(cfg_sh), .cfg_neg(cfg_neg), .cfg_en(cfg_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint          r;
      logic [TW-1:0]   tag;
      int              acc_cyc;
   } exp_t;

   exp_t          exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            cyc = 0;
   bit            lat_chk = 1'b0;
   bit            stall_prev = 1'b0;
   bit            acc_now = 1'b0;
   logic [OW-1:0] held_r = '0;
   logic [TW-1:0] held_tag = '0;
   longint        mq = 0;
   longint        mk = 0;
   longint        pend_q = 0;
   longint        pend_k = 0;
   longint        dir_exp = -1;
   logic [TW-1:0] tag_ctr = '0;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference: R = K^2 * A mod Q, using plain modular arithmetic.
   function automatic longint ref_red(input longint a);
      longint k2;
      k2 = (mk * mk) % mq;
      return ((a % mq) * k2) % mq;
   endfunction

   // Evaluate one clock cycle. Inputs are already driven at the falling edge.
   // The DUT is sampled 1 time unit later, well before the rising edge.
   task automatic cycle();
      bit     cfg_exp;
      exp_t   e;
      longint obs;
      #1;
      cfg_exp = (exp_q.size() == 0);
      check("cfg_ready", cfg_ready, cfg_exp);
      check("in_ready", in_ready, (!out_valid || out_ready) && !(cfg_we && cfg_exp));
      if (stall_prev) begin
         check("hold_valid", out_valid, 1);
         check("hold_r", out_r, held_r);
         check("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 0);
         end else begin
            e = exp_q.pop_front();
`ifdef K2RED_LAZY_OUT_EN
            obs = $signed(out_r);
            check("r_mod", ((obs % mq) + mq) % mq, e.r);
            check("r_range", (obs > -mq) && (obs < 2*mq), 1);
`else
            obs = longint'(out_r);
            check("r", out_r, e.r);
`endif
            check("tag", out_tag, e.tag);
            if (lat_chk) check("latency", cyc - e.acc_cyc, LAT);
            $display("xfer cyc=%0d tag=%0d r=%0d exp=%0d", cyc, out_tag, obs, e.r);
         end
      end
      stall_prev = out_valid && !out_ready;
      held_r     = out_r;
      held_tag   = out_tag;
      if (cfg_we && cfg_exp) begin
         mq = pend_q;
         mk = pend_k;
      end
      acc_now = in_valid && in_ready;
      if (acc_now)
         exp_q.push_back('{(dir_exp >= 0) ? dir_exp : ref_red(longint'(in_a)), in_tag, cyc});
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive_cfg(input longint q, input int m, input logic [NT*SW-1:0] sh,
                            input logic [NT-1:0] neg, input logic [NT-1:0] en);
      pend_q = q;
      pend_k = 0;
      for (int i = 0; i < NT; i++)
         if (en[i]) pend_k += neg[i] ? -(longint'(1) << sh[i*SW +: SW])
                                     :  (longint'(1) << sh[i*SW +: SW]);
      cfg_q   = W'(q);
      cfg_m   = SW'(m);
      cfg_sh  = sh;
      cfg_neg = neg;
      cfg_en  = en;
      cfg_we  = 1'b1;
      in_valid = 1'b0;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic send(input longint a, input longint exp_r);
      int budget;
      budget   = 0;
      in_valid = 1'b1;
      in_a     = AW'(a);
      in_tag   = tag_ctr;
      dir_exp  = exp_r;
      do begin
         cycle();
         budget++;
      end while (!acc_now && budget < 100);
      if (!acc_now) check("send_timeout", acc_now, 1);
      tag_ctr++;
      in_valid = 1'b0;
      dir_exp  = -1;
   endtask

   task automatic drain();
      int budget;
      budget    = 0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && budget < 100) begin
         cycle();
         budget++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   function automatic longint rand_a();
      return ((longint'($urandom()) << 20) ^ longint'($urandom())) % (mq * mq);
   endfunction

   // Stream nw random words while out_ready follows a fixed stall pattern.
   task automatic bp_run(input int nw);
      bit     pat [8] = '{1, 0, 0, 0, 1, 0, 1, 1};
      longint a;
      int     n;
      n = 0;
      a = (mq - 1) * (mq - 1);
      for (int t = 0; t < 400 && (n < nw || exp_q.size() > 0); t++) begin
         out_ready = pat[t % 8];
         in_valid  = (n < nw);
         in_a      = AW'(a);
         in_tag    = tag_ctr;
         cycle();
         if (acc_now) begin
            n++;
            tag_ctr++;
            a = rand_a();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_words", n, nw);
      check("bp_empty", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_r", out_r, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_cfg_ready", cfg_ready, 1);
      @(negedge clk);

      // Q = 3329: M = 8, K = 2^3 + 2^2 + 2^0 = 13
      drive_cfg(3329, 8, {6'd0, 6'd0, 6'd2, 6'd3}, 4'b0000, 4'b0111);
      lat_chk = 1'b1;
      send(0, 0);
      send(1, 169);
      send(2, 338);
      send(11075584, 169);
      drain();
      lat_chk = 1'b0;

      bp_run(20);

      // Q = 8380417: M = 13, K = 2^10 - 2^0 = 1023
      drive_cfg(8380417, 13, {6'd0, 6'd0, 6'd0, 6'd10}, 4'b0010, 4'b0011);
      lat_chk = 1'b1;
      send(1, 1046529);
      send(longint'(8380416) * 8380416, 1046529);
      drain();
      lat_chk = 1'b0;

      bp_run(8);

      // A configuration write is refused while words are in flight.
      send(rand_a(), -1);
      send(rand_a(), -1);
      send(rand_a(), -1);
      drive_cfg(3329, 8, {6'd0, 6'd0, 6'd2, 6'd3}, 4'b0000, 4'b0111);
      drain();
      drive_cfg(3329, 8, {6'd0, 6'd0, 6'd2, 6'd3}, 4'b0000, 4'b0111);
      send(5, 845);
      send(rand_a(), -1);
      drain();

      // Reset with words in flight discards them all.
      for (int i = 0; i < 4; i++) send(rand_a(), -1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      stall_prev = 1'b0;
      mq = 0;
      mk = 0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_cfg_ready", cfg_ready, 1);
      for (int i = 0; i < 10; i++) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // A hard time limit keeps the bench from hanging.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/k2red_stream.md
Name: k2red_stream

Overview:
- Streaming, fully pipelined K2-RED modular reduction for Proth-form primes Q = K*2^M + 1, with K a sum of up to NT signed powers of two.
- For each input A < Q^2 it returns R = K^2*A mod Q, in the range [0, Q).
- Successor to the fixed 4-term shift reducer. It adds runtime-loadable prime configuration, a parametrised term count, a valid/ready handshake with back-pressure, and a sideband tag.
- Sits between the NTT butterfly multiplier and the coefficient write-back path.

Parameters:
- W, 32, coefficient width; Q < 2^W.
- NT, 4, maximum number of signed power-of-two terms in K.
- TW, 4, width of the in_tag/out_tag sideband.
- SW, derived as $clog2(2*W), width of each shift amount and of M.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept an input this cycle
- in_a  in  2*W  product to reduce; must be < Q^2
- in_tag  in  TW  sideband, carried unchanged to the output
- out_valid  out  1  result valid
- out_ready  in  1  downstream can accept a result
- out_r  out  W  reduced result
- out_tag  out  TW  tag belonging to out_r
- cfg_we  in  1  configuration write strobe
- cfg_ready  out  1  pipeline is empty, so a configuration write is accepted
- cfg_q  in  W  prime Q
- cfg_m  in  SW  split point M
- cfg_sh  in  NT*SW  shift amount of each term; term i occupies bits [i*SW +: SW]
- cfg_neg  in  NT  term i is subtracted when set
- cfg_en  in  NT  term i takes part in K when set

Behaviour:
- Arithmetic: K = sum over enabled terms i of (cfg_neg[i] ? -2^sh_i : +2^sh_i).
- Reduction round, applied to X: XL = X[M-1:0] (unsigned), XH = X >>> M (arithmetic shift); result = K*XL - XH, built from shifts and adds only (no multipliers).
- Internal datapath is signed, 2W+2 bits wide; no intermediate result may truncate.
- Pipeline stages, each registered:
  - S0: split in_a into AL/AH.
  - S1: C1 = round(A).
  - S2: split C1.
  - S3: C2 = round(C1).
  - S4: correction. If C2 >= Q then R = C2 - Q; else if C2 < 0 then R = C2 + Q; else R = C2.
- Latency: 5 cycles from input accept to out_valid when out_ready is held high. Throughput: 1 result per cycle.
- Flow control: one global advance signal, adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv is low, every stage (data, tag, valid bit) holds its contents.
  - Inputs are accepted on in_valid && in_ready.
  - out_r and out_tag stay stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order. No result is dropped or duplicated under any out_ready pattern.
- Configuration:
  - cfg_ready = 1 when all five stage-valid bits are 0.
  - cfg_we && cfg_ready latches all cfg_* fields into config registers in one cycle; they take effect for inputs accepted from the next cycle on.
  - cfg_we while cfg_ready = 0 is ignored and configuration is unchanged.
  - While a configuration write is accepted, in_ready is forced to 0 in that cycle.
- Reset:
  - All stage-valid bits, out_valid, out_r and out_tag go to 0.
  - Config resets to Q = 0, M = 0, all terms disabled.
  - in_ready = 1 and cfg_ready = 1 in the cycle after reset.
  - Reset mid-stream discards all in-flight words.
- Boundary conditions:
  - A = 0 gives R = 0.
  - A = (Q-1)^2 gives R = K^2 mod Q.
  - An input with A >= Q^2 gives an undefined result, but the handshake is unaffected.
  - All terms disabled: K = 0, so R = (-A_H terms) mod Q. No special handling.
- Simultaneous in_valid and a blocked output: the input is not accepted, and in_ready is 0 that cycle.

Optional Feature:
- Macro: K2RED_LAZY_OUT_EN.
- When defined:
  - Stage S4 is removed; latency is 4 cycles.
  - out_r is C2 truncated to W+2 bits, signed, and out_r widens to W+2. The result lies in (-Q, 2Q) and is congruent to K^2*A mod Q.
  - This is intended for consumers that do lazy reduction.
- When undefined: behaviour is exactly as specified above, including the fully reduced W-bit output.

Test Plan:
- W=12, Q=3329 (M=8, K=13 = 2^3+2^2+2^0), inputs A=0, 1, 2, 11075584 with out_ready=1 -> R = 0, 169, 338, 169, first result 5 cycles after the first accept, one result per cycle, tags returned in order.
- W=24, Q=8380417 (M=13, K=1023 = 2^10-2^0, term 1 with neg set), A=1 -> R = 1046529; A=8380416^2 -> R = 1046529.
- Back-pressure: stream 8 random valid A while out_ready toggles 1,0,0,0,1,0,1,1… -> all 8 results match a software model of K^2*A mod Q, in order; out_r and out_tag stable while stalled; in_ready = 0 whenever out_valid && !out_ready.
- Config guard: cfg_we asserted while 3 words are in flight -> cfg_ready = 0 and config unchanged; retried once drained -> accepted, and the next input is reduced with the new Q.
- Reset mid-stream: assert rst with 4 words in flight -> next cycle out_valid = 0, in_ready = 1, cfg_ready = 1; no stale result ever appears.
- K2RED_LAZY_OUT_EN build: Q=3329, A=1 -> out_r ≡ 169 (mod 3329) and within (-3329, 6658), latency 4 cycles.
